// File: rtl/fc_mac_array.sv
// fc_mac_array: fully-connected layer MAC array.
// NUM_CH output neurons run in parallel. Each accepted input beat carries one
// signed activation (i_node) that is shared by all channels, plus one signed
// weight per channel (i_wegt). Every channel keeps a 4*DATA_WIDTH accumulator
// that wraps on overflow. After the last beat, the latched bias is added in a
// single cycle. The result is then held in DONE until downstream accepts it.
//
// Handshakes (strict valid/ready): an input beat transfers on a rising edge
// where i_valid && o_ready. A result transfers on a rising edge where
// o_valid && i_result_ready. A source that raises valid keeps its payload
// stable until the transfer. o_result is stable for the whole DONE state.
//
// Ports:
//   clk, reset      - rising-edge clock, synchronous active-high reset
//   i_run           - start pulse; acted on only while o_idle=1
//   i_num_node      - number of beats in the run (sampled with i_run)
//   i_bias          - per-channel signed bias (sampled with i_run)
//   i_valid/o_ready - input beat handshake; o_ready is high only in ACC
//   i_node, i_wegt  - shared activation, per-channel weights
//   o_valid/i_result_ready - result handshake; o_valid is high only in DONE
//   o_result        - per-channel accumulators, channel c at [c*4*DW +: 4*DW]
//   o_idle          - high only in IDLE
//   dbg_state       - current FSM state (IDLE=0, ACC=1, BIAS=2, DONE=3)
//
// Configuration: define FC_MAC_RELU_EN to clamp negative channel results to 0
// on o_result. When it is undefined, o_result is the raw signed accumulator.
module fc_mac_array #(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_CH     = 4,
   parameter int CNT_WIDTH  = 10
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             i_run,
   input  logic [CNT_WIDTH-1:0]             i_num_node,
   input  logic [NUM_CH*DATA_WIDTH-1:0]     i_bias,
   input  logic                             i_valid,
   output logic                             o_ready,
   input  logic [DATA_WIDTH-1:0]            i_node,
   input  logic [NUM_CH*DATA_WIDTH-1:0]     i_wegt,
   output logic                             o_valid,
   input  logic                             i_result_ready,
   output logic [NUM_CH*4*DATA_WIDTH-1:0]   o_result,
   output logic                             o_idle,
   output logic [1:0]                       dbg_state
);

   localparam int ACC_W = 4 * DATA_WIDTH;
   localparam int PRD_W = 2 * DATA_WIDTH;

   typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, BIAS = 2'd2, DONE = 2'd3} state_t;

   state_t                               state;
   logic [CNT_WIDTH-1:0]                 num_node;
   logic [CNT_WIDTH-1:0]                 beat_cnt;
   logic [CNT_WIDTH-1:0]                 cnt_next;
   logic [NUM_CH-1:0][DATA_WIDTH-1:0]    bias_q;
   logic [NUM_CH-1:0][ACC_W-1:0]         acc;
   logic [NUM_CH-1:0][ACC_W-1:0]         prod_ext;
   logic [NUM_CH-1:0][ACC_W-1:0]         bias_ext;
   logic signed [PRD_W-1:0]              prod [NUM_CH];

   assign cnt_next  = beat_cnt + CNT_WIDTH'(1);
   assign dbg_state = state;

   // Full-precision signed products and sign-extended biases, widened to the
   // accumulator width so that the add below is a plain modulo-2^ACC_W add.
   always_comb begin
      prod_ext = '0;
      bias_ext = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         prod[c]     = $signed(i_node) * $signed(i_wegt[c*DATA_WIDTH +: DATA_WIDTH]);
         prod_ext[c] = {{(ACC_W-PRD_W){prod[c][PRD_W-1]}}, prod[c]};
         bias_ext[c] = {{(ACC_W-DATA_WIDTH){bias_q[c][DATA_WIDTH-1]}}, bias_q[c]};
      end
   end

   // FSM plus datapath. o_ready/o_valid/o_idle are registered. Each one is
   // written together with the state it belongs to, so it always matches the
   // state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         acc      <= '0;
         beat_cnt <= '0;
         num_node <= '0;
         bias_q   <= '0;
         o_ready  <= 1'b0;
         o_valid  <= 1'b0;
         o_idle   <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (i_run) begin
                  num_node <= i_num_node;
                  bias_q   <= i_bias;
                  acc      <= '0;
                  beat_cnt <= '0;
                  o_idle   <= 1'b0;
                  if (i_num_node == '0) begin
                     state <= BIAS;
                  end else begin
                     state   <= ACC;
                     o_ready <= 1'b1;
                  end
               end
            end
            ACC: begin
               // o_ready is 1 throughout ACC, so i_valid alone marks a beat.
               if (i_valid) begin
                  for (int c = 0; c < NUM_CH; c++) begin
                     acc[c] <= acc[c] + prod_ext[c];
                  end
                  beat_cnt <= cnt_next;
                  if (cnt_next == num_node) begin
                     state   <= BIAS;
                     o_ready <= 1'b0;
                  end
               end
            end
            BIAS: begin
               for (int c = 0; c < NUM_CH; c++) begin
                  acc[c] <= acc[c] + bias_ext[c];
               end
               state   <= DONE;
               o_valid <= 1'b1;
            end
            DONE: begin
               // A new i_run is not looked at here. A fresh run can only start
               // from IDLE, one cycle after the handoff.
               if (i_result_ready) begin
                  state   <= IDLE;
                  o_valid <= 1'b0;
                  o_idle  <= 1'b1;
               end
            end
            default: begin
               state   <= IDLE;
               o_ready <= 1'b0;
               o_valid <= 1'b0;
               o_idle  <= 1'b1;
            end
         endcase
      end
   end

   // The output is taken straight from the accumulator registers.
   always_comb begin
      o_result = '0;
      for (int c = 0; c < NUM_CH; c++) begin
`ifdef FC_MAC_RELU_EN
         o_result[c*ACC_W +: ACC_W] = acc[c][ACC_W-1] ? '0 : acc[c];
`else
         o_result[c*ACC_W +: ACC_W] = acc[c];
`endif
      end
   end

endmodule

// File: tb/tb_fc_mac_array.sv
// tb_fc_mac_array: self-checking bench for fc_mac_array (defaults 16/4/10).
// A longint reference model computes each run's expected results. These are
// pushed to exp_q when the run is driven. They are popped and compared when
// the DUT presents o_valid.
module tb_fc_mac_array;

   localparam int DW  = 16;
   localparam int NCH = 4;
   localparam int CW  = 10;
   localparam int AW  = 4 * DW;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 i_run;
   logic [CW-1:0]        i_num_node;
   logic [NCH*DW-1:0]    i_bias;
   logic                 i_valid;
   logic                 o_ready;
   logic [DW-1:0]        i_node;
   logic [NCH*DW-1:0]    i_wegt;
   logic                 o_valid;
   logic                 i_result_ready;
   logic [NCH*AW-1:0]    o_result;
   logic                 o_idle;
   logic [1:0]           dbg_state;

   int checks = 0;
   int errors = 0;

   logic [NCH*AW-1:0]    exp_q[$];
   logic [DW-1:0]        node_tab [0:7];
   logic [NCH*DW-1:0]    wegt_tab [0:7];

   fc_mac_array #(.DATA_WIDTH(DW), .NUM_CH(NCH), .CNT_WIDTH(CW)) dut (
      .clk            (clk),
      .reset          (reset),
      .i_run          (i_run),
      .i_num_node     (i_num_node),
      .i_bias         (i_bias),
      .i_valid        (i_valid),
      .o_ready        (o_ready),
      .i_node         (i_node),
      .i_wegt         (i_wegt),
      .o_valid        (o_valid),
      .i_result_ready (i_result_ready),
      .o_result       (o_result),
      .o_idle         (o_idle),
      .dbg_state      (dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // Output view of one channel value.
   function automatic logic [AW-1:0] out_ch(input longint v);
`ifdef FC_MAC_RELU_EN
      if (v < 0) return '0;
`endif
      return v;
   endfunction

   // Check the idle/reset output state. Sampled on the falling edge.
   task automatic check_idle_outputs(input string name);
      checks++;
      if (o_idle !== 1'b1 || o_ready !== 1'b0 || o_valid !== 1'b0 || o_result !== '0) begin
         errors++;
         $display("FAIL %s idle=%b ready=%b valid=%b result=%h expected idle=1 ready=0 valid=0 result=0",
                  name, o_idle, o_ready, o_valid, o_result);
      end
   endtask

   // Drive one complete run and score it.
   //   gap            - idle i_valid cycles between beats
   //   hold           - extra DONE cycles with i_result_ready=0
   //   run_at_handoff - raise i_run together with i_result_ready
   //   inject_run     - raise i_run alongside every beat (must be ignored)
   //   poke/acc0      - preload accumulator ch0 once the run is in ACC
   task automatic run_job(input int n, input logic [NCH*DW-1:0] bias, input int gap,
                          input int hold, input bit run_at_handoff, input bit inject_run,
                          input bit poke, input longint acc0);
      longint            s [NCH];
      logic [NCH*AW-1:0] exp_v;
      logic [NCH*AW-1:0] e;
      for (int c = 0; c < NCH; c++) begin
         s[c] = longint'($signed(bias[c*DW +: DW]));
         if (poke && c == 0) s[c] += acc0;
         for (int b = 0; b < n; b++)
            s[c] += longint'($signed(node_tab[b])) * longint'($signed(wegt_tab[b][c*DW +: DW]));
         exp_v[c*AW +: AW] = out_ch(s[c]);
      end
      exp_q.push_back(exp_v);

      @(negedge clk);
      checks++;
      if (o_idle !== 1'b1) begin
         errors++;
         $display("FAIL start_idle o_idle=%b expected 1", o_idle);
      end
      i_run = 1'b1; i_num_node = CW'(n); i_bias = bias;
      @(negedge clk);
      i_run = 1'b0; i_bias = {$urandom, $urandom};
      if (poke) dut.acc[0] = acc0;

      for (int b = 0; b < n; b++) begin
         checks++;
         if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_acc beat=%0d o_ready=%b expected 1", b, o_ready);
         end
         i_valid = 1'b1; i_node = node_tab[b]; i_wegt = wegt_tab[b];
         if (inject_run) begin
            i_run = 1'b1; i_num_node = CW'(5); i_bias = {$urandom, $urandom};
         end
         @(negedge clk);
         i_valid = 1'b0; i_run = 1'b0;
         i_node = DW'($urandom); i_wegt = {$urandom, $urandom};
         if (b != n - 1) begin
            for (int g = 0; g < gap; g++) begin
               checks++;
               if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
                  errors++;
                  $display("FAIL stall beat=%0d ready=%b valid=%b expected ready=1 valid=0", b, o_ready, o_valid);
               end
               @(negedge clk);
            end
         end
      end

      // One cycle after the last beat (or after i_run when n=0): BIAS.
      checks++;
      if (o_valid !== 1'b0 || o_ready !== 1'b0 || o_idle !== 1'b0) begin
         errors++;
         $display("FAIL bias_cycle valid=%b ready=%b idle=%b expected 0 0 0", o_valid, o_ready, o_idle);
      end
      @(negedge clk);
      checks++;
      if (o_valid !== 1'b1 || o_ready !== 1'b0) begin
         errors++;
         $display("FAIL latency valid=%b ready=%b expected valid=1 ready=0", o_valid, o_ready);
      end

      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         checks++;
         if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_result !== exp_v) begin
            errors++;
            $display("FAIL hold_stable cycle=%0d valid=%b ready=%b result=%h expected valid=1 ready=0 result=%h",
                     h, o_valid, o_ready, o_result, exp_v);
         end
      end

      i_result_ready = 1'b1;
      if (run_at_handoff) begin
         i_run = 1'b1; i_num_node = CW'(2);
      end
      if (exp_q.size() == 0) begin
         checks++; errors++;
         $display("FAIL scoreboard_empty result=%h", o_result);
      end else begin
         e = exp_q.pop_front();
         checks++;
         if (o_result !== e) begin
            errors++;
            $display("FAIL result got=%h expected=%h", o_result, e);
         end
      end
      @(negedge clk);
      i_result_ready = 1'b0; i_run = 1'b0;
      checks++;
      if (o_valid !== 1'b0 || o_idle !== 1'b1) begin
         errors++;
         $display("FAIL handoff valid=%b idle=%b expected valid=0 idle=1", o_valid, o_idle);
      end
      if (run_at_handoff) begin
         @(negedge clk);
         checks++;
         if (o_idle !== 1'b1 || o_ready !== 1'b0) begin
            errors++;
            $display("FAIL run_at_handoff idle=%b ready=%b expected idle=1 ready=0", o_idle, o_ready);
         end
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b1; i_run = 1'b1; i_num_node = CW'(3);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_idle_outputs("reset_held");
      end
      reset = 1'b0; i_run = 1'b0;
      @(negedge clk);
      check_idle_outputs("reset_release");
   endtask

   task automatic load_basic();
      logic [NCH*DW-1:0] w;
      w = {16'sd0, 16'sd2, -16'sd1, 16'sd1};
      node_tab[0] = 16'd1; node_tab[1] = 16'd2; node_tab[2] = 16'd3;
      for (int b = 0; b < 3; b++) wegt_tab[b] = w;
   endtask

   task automatic test_basic();
      logic [NCH*DW-1:0] bias;
      bias = {16'sd7, -16'sd5, 16'sd10, 16'sd10};
      load_basic();
      run_job(3, bias, 0, 0, 1'b0, 1'b0, 1'b0, 0);
   endtask

   task automatic test_stall_hold();
      logic [NCH*DW-1:0] bias;
      bias = {16'sd7, -16'sd5, 16'sd10, 16'sd10};
      load_basic();
      run_job(3, bias, 2, 5, 1'b1, 1'b0, 1'b0, 0);
   endtask

   task automatic test_zero_nodes();
      logic [NCH*DW-1:0] bias;
      bias = {16'sd9, 16'sd4, -16'sd3, 16'sd5};
      run_job(0, bias, 0, 1, 1'b0, 1'b0, 1'b0, 0);
   endtask

   task automatic test_wrap();
      node_tab[0] = 16'd1;
      wegt_tab[0] = {16'd0, 16'd0, 16'd0, 16'd1};
      run_job(1, '0, 0, 0, 1'b0, 1'b0, 1'b1, 64'sh7FFF_FFFF_FFFF_FFFF);
   endtask

   task automatic test_abort();
      load_basic();
      @(negedge clk);
      i_run = 1'b1; i_num_node = CW'(3); i_bias = {4{16'sd100}};
      @(negedge clk);
      i_run = 1'b0;
      for (int b = 0; b < 2; b++) begin
         i_valid = 1'b1; i_node = node_tab[b]; i_wegt = wegt_tab[b];
         @(negedge clk);
      end
      i_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      check_idle_outputs("abort_reset");
      reset = 1'b0;
      @(negedge clk);
      check_idle_outputs("abort_release");
      for (int b = 0; b < 3; b++) begin
         node_tab[b] = 16'd1;
         wegt_tab[b] = {16'd0, 16'd0, 16'd0, 16'd1};
      end
      run_job(3, '0, 1, 0, 1'b0, 1'b1, 1'b0, 0);
   endtask

   task automatic test_random();
      for (int r = 0; r < 4; r++) begin
         int n;
         n = $urandom_range(6, 1);
         for (int b = 0; b < n; b++) begin
            node_tab[b] = DW'($urandom);
            wegt_tab[b] = {$urandom, $urandom};
         end
         run_job(n, {$urandom, $urandom}, $urandom_range(2, 0), $urandom_range(3, 0),
                 1'b0, 1'b0, 1'b0, 0);
      end
   endtask

   initial begin
      reset = 1'b1; i_run = 1'b0; i_num_node = '0; i_bias = '0; i_valid = 1'b0;
      i_node = '0; i_wegt = '0; i_result_ready = 1'b0;
      test_reset();
      test_basic();
      test_stall_hold();
      test_zero_nodes();
      test_wrap();
      test_abort();
      test_random();
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_leftover entries=%0d expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
